// File: rtl/ps2_keyboard_mmio_if.sv
// CPU data-bus slice seen by the PS/2 keyboard responder.
// The CPU side drives strobes, address and write data; the responder returns read data.
interface ps2_keyboard_mmio_if;
   logic        Keyboard_Select_H;
   logic        AS_L;
   logic        WE_L;
   logic [3:0]  Byte_Enable;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;

   modport master (
      output Keyboard_Select_H, AS_L, WE_L, Byte_Enable, Address, DataIn,
      input  DataOut
   );
   modport slave (
      input  Keyboard_Select_H, AS_L, WE_L, Byte_Enable, Address, DataIn,
      output DataOut
   );
endinterface

// File: rtl/ps2_keyboard_mmio.sv
// Memory-mapped PS/2 keyboard receiver: it conditions the raw lines, deframes
// device-to-host bytes, and queues good scan codes in a FIFO read over the CPU bus.
module ps2_keyboard_mmio #(
   parameter int FIFO_DEPTH     = 16,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              Clock,
   input  logic              Reset_L,
   ps2_keyboard_mmio_if.slave bus,
   input  logic              PS2_CLK,
   input  logic              PS2_DAT,
   output logic              IRQ_H
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   // ---------------- input conditioning ----------------
   logic [1:0]    clk_sync, dat_sync;
   logic          clk_filt, ps2_fall, ps2_bit;
   logic [FW-1:0] filt_cnt;

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
      end
   end

   // ps2_fall is a one-cycle strobe; ps2_bit holds DAT captured at that edge
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         ps2_fall <= 1'b0;
         ps2_bit  <= 1'b1;
      end else begin
         ps2_fall <= 1'b0;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
            ps2_fall <= clk_filt;
            ps2_bit  <= dat_sync[1];
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   // ---------------- receive FSM ----------------
   rx_state_t     state, state_nxt;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          par_bit, frame_done, timeout;
   logic [TW-1:0] to_cnt;

   assign timeout = (state != RX_IDLE) && !ps2_fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) state <= RX_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         RX_IDLE:   if (ps2_fall && !ps2_bit) state_nxt = RX_DATA;
         RX_DATA:   if (ps2_fall && bit_cnt == 3'd7) state_nxt = RX_PARITY;
         RX_PARITY: if (ps2_fall) state_nxt = RX_STOP;
         RX_STOP:   if (ps2_fall) begin
                       state_nxt  = RX_IDLE;
                       frame_done = 1'b1;
                    end
         default:   state_nxt = RX_IDLE;
      endcase
      if (timeout) state_nxt = RX_IDLE;
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         shreg   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
         to_cnt  <= '0;
      end else begin
         if (state == RX_IDLE || ps2_fall) to_cnt <= '0;
         else                              to_cnt <= to_cnt + TW'(1);
         if (ps2_fall) begin
            case (state)
               RX_IDLE:   if (!ps2_bit) begin
                             shreg   <= '0;
                             bit_cnt <= '0;
                          end
               RX_DATA:   begin
                             shreg   <= {ps2_bit, shreg[7:1]};
                             bit_cnt <= bit_cnt + 3'd1;
                          end
               RX_PARITY: par_bit <= ps2_bit;
               default:   ;
            endcase
         end
      end
   end

   // ---------------- frame checks / FIFO ----------------
   logic          odd_ok, fifo_full, push, pop;
   logic          perr_set, ferr_set, ovr_set;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;

   assign odd_ok    = ^{par_bit, shreg};
   assign fifo_full = (count == CW'(FIFO_DEPTH));
   assign perr_set  = frame_done && !odd_ok;
   assign ferr_set  = frame_done && odd_ok && !ps2_bit;
   assign ovr_set   = frame_done && odd_ok && ps2_bit && fifo_full;
   assign push      = frame_done && odd_ok && ps2_bit && !fifo_full;

   always_ff @(posedge Clock) begin
      if (push) mem[wptr] <= shreg;
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // ---------------- bus interface ----------------
   logic       acc_act, acc_q, rd0_q, wr_stb, ie, ovr, perr, ferr;
   logic [1:0] off;
   logic [7:0] head;
   logic [31:0] rd_data;

   assign off     = bus.Address[3:2];
   assign acc_act = bus.Keyboard_Select_H && !bus.AS_L;
   assign wr_stb  = acc_act && !acc_q && !bus.WE_L && bus.Byte_Enable[0];
   // pop lands on the edge where a DATA read access has just ended
   assign pop     = rd0_q && !acc_act && (count != '0);
   assign head    = (count != '0) ? mem[rptr] : 8'h00;

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         acc_q <= 1'b0;
         rd0_q <= 1'b0;
         ie    <= 1'b0;
         ovr   <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         IRQ_H <= 1'b0;
      end else begin
         acc_q <= acc_act;
         rd0_q <= acc_act && bus.WE_L && (off == 2'd0);
         if (wr_stb && off == 2'd2) ie <= bus.DataIn[0];
         ovr   <= (ovr  && !(wr_stb && off == 2'd1 && bus.DataIn[1])) || ovr_set;
         perr  <= (perr && !(wr_stb && off == 2'd1 && bus.DataIn[2])) || perr_set;
         ferr  <= (ferr && !(wr_stb && off == 2'd1 && bus.DataIn[3])) || ferr_set;
         IRQ_H <= ie && (count != '0);
      end
   end

   always_comb begin
      rd_data = '0;
      if (acc_act) begin
         case (off)
            2'd0: rd_data[7:0] = head;
            2'd1: begin
                     rd_data[0]    = (count != '0);
                     rd_data[1]    = ovr;
                     rd_data[2]    = perr;
                     rd_data[3]    = ferr;
                     rd_data[14:8] = 7'(count);
                  end
            2'd2: rd_data[0] = ie;
            default: ;
         endcase
      end
   end

   assign bus.DataOut = rd_data;

   logic unused_bits;
   assign unused_bits = ^{bus.Address[31:4], bus.Address[1:0],
                          bus.Byte_Enable[3:1], bus.DataIn[31:4]};
endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// Randomized bench for ps2_keyboard_mmio: frames and bus traffic are checked
// against a queue-based model of the receiver and register map.
module tb_ps2_keyboard_mmio;
   logic Clock = 1'b0, Reset_L = 1'b0, PS2_CLK = 1'b1, PS2_DAT = 1'b1;
   logic IRQ_H;
   int   n_chk = 0, n_pass = 0;

   ps2_keyboard_mmio_if bus();

   ps2_keyboard_mmio dut (
      .Clock(Clock), .Reset_L(Reset_L), .bus(bus),
      .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .IRQ_H(IRQ_H)
   );

   always #5 Clock = ~Clock;

   // reference model
   logic [7:0] mq[$];
   bit m_ovr, m_perr, m_ferr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_status();
      return {17'h0, 7'(mq.size()), 4'h0, m_ferr, m_perr, m_ovr, mq.size() != 0};
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge Clock);
   endtask

   task automatic bus_idle();
      bus.Keyboard_Select_H = 1'b0; bus.AS_L = 1'b1; bus.WE_L = 1'b1;
      bus.Byte_Enable = 4'h0; bus.Address = '0; bus.DataIn = '0;
   endtask

   task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
      @(negedge Clock);
      bus.Keyboard_Select_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b1;
      bus.Address = {28'h0, off, 2'b00};
      @(posedge Clock); #1 d = bus.DataOut;
      @(negedge Clock); bus_idle();
      @(posedge Clock); #1;
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
      @(negedge Clock);
      bus.Keyboard_Select_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b0;
      bus.Address = {28'h0, off, 2'b00}; bus.DataIn = d; bus.Byte_Enable = be;
      wait_clk(3);
      @(negedge Clock); bus_idle();
      @(posedge Clock); #1;
      if (be[0] && off == 2'd1) begin
         if (d[1]) m_ovr = 0;
         if (d[2]) m_perr = 0;
         if (d[3]) m_ferr = 0;
      end
   endtask

   task automatic read_data_chk(input string tag);
      logic [31:0] d, e;
      bus_read(2'd0, d);
      e = (mq.size() != 0) ? {24'h0, mq.pop_front()} : 32'h0;
      chk(tag, d, e);
   endtask

   task automatic status_chk(input string tag);
      logic [31:0] d;
      bus_read(2'd1, d);
      chk(tag, d, exp_status());
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic par;
      par = (~^d) ^ bad_par;
      return {~bad_stop, par, d, 1'b0};
   endfunction

   // drives nbits of a frame, LSB (start bit) first; glitch adds short pulses
   task automatic ps2_bits(input logic [10:0] f, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = f[i];
         if (glitch && i == 3) begin
            wait_clk(5); PS2_CLK = 1'b0; wait_clk(5); PS2_CLK = 1'b1; wait_clk(15);
         end else wait_clk(15);
         PS2_CLK = 1'b0;
         if (glitch && i == 6) begin
            wait_clk(14); PS2_CLK = 1'b1; wait_clk(5); PS2_CLK = 1'b0; wait_clk(10);
         end else wait_clk(15);
         PS2_CLK = 1'b1;
      end
      PS2_DAT = 1'b1;
      wait_clk(20);
   endtask

   task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit glitch);
      logic [10:0] f;
      f = frame_of(d, bad_par, bad_stop);
      ps2_bits(f, 11, glitch);
      if ($countones(f[9:1]) % 2 == 0) m_perr = 1;
      else if (!f[10])                 m_ferr = 1;
      else if (mq.size() >= 16)        m_ovr = 1;
      else                             mq.push_back(d);
   endtask

   initial begin : main
      logic [31:0] d;
      int t_push, t_irq;
      bus_idle();

      // reset state, observed while reset is held
      wait_clk(3);
      @(negedge Clock);
      bus.Keyboard_Select_H = 1'b1; bus.AS_L = 1'b0; bus.Address = 32'h4;
      #1 chk("reset_status", bus.DataOut, 32'h0);
      chk("reset_irq", {31'h0, IRQ_H}, 32'h0);
      bus_idle();
      wait_clk(2);
      Reset_L = 1'b1;
      wait_clk(5);

      // single good frame
      send(8'h1C, 0, 0, 0);
      status_chk("1c_status_pre");
      read_data_chk("1c_data");
      status_chk("1c_status_post");

      // fill and overflow
      for (int i = 1; i <= 17; i++) send(8'(i), 0, 0, 0);
      bus_read(2'd1, d);
      chk("ovr_status", d, 32'h0000_1003);
      for (int i = 1; i <= 17; i++) begin
         bus_read(2'd0, d);
         chk($sformatf("drain_%0d", i), d, (i <= 16) ? 32'(i) : 32'h0);
         if (mq.size() != 0) void'(mq.pop_front());
      end
      status_chk("ovr_after_drain");
      bus_write(2'd1, 32'h2, 4'h1);
      status_chk("ovr_cleared");

      // parity error and W1C
      send(8'h1C, 1, 0, 0);
      bus_read(2'd1, d);
      chk("perr_status", d, 32'h4);
      bus_write(2'd1, 32'h4, 4'h1);
      bus_read(2'd1, d);
      chk("perr_cleared", d, 32'h0);

      // framing error; a W1C without Byte_Enable[0] must not clear
      send(8'h33, 0, 1, 0);
      bus_write(2'd1, 32'h8, 4'h2);
      status_chk("ferr_be_gated");
      bus_write(2'd1, 32'h8, 4'h1);
      status_chk("ferr_cleared");

      // interrupt timing
      bus_write(2'd2, 32'h1, 4'h1);
      bus_read(2'd2, d);
      chk("ctrl_ie", d, 32'h1);
      t_push = -1; t_irq = -1;
      @(negedge Clock);
      bus.Keyboard_Select_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b1; bus.Address = 32'h4;
      fork
         send(8'hF0, 0, 0, 0);
         for (int c = 0; c < 600; c++) begin
            @(posedge Clock); #1;
            if (t_push < 0 && bus.DataOut[0]) t_push = c;
            if (t_irq < 0 && IRQ_H) t_irq = c;
         end
      join
      bus_idle();
      chk("irq_push_seen", {31'h0, t_push >= 0}, 32'h1);
      chk("irq_rise_lat", 32'(t_irq - t_push), 32'h1);
      @(negedge Clock);
      bus.Keyboard_Select_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b1; bus.Address = 32'h0;
      @(posedge Clock); #1 d = bus.DataOut;
      chk("irq_data", d, {24'h0, mq.pop_front()});
      @(negedge Clock); bus_idle();
      @(posedge Clock); #1 chk("irq_hold_at_pop", {31'h0, IRQ_H}, 32'h1);
      @(posedge Clock); #1 chk("irq_fall", {31'h0, IRQ_H}, 32'h0);
      bus_write(2'd2, 32'h0, 4'h1);

      // abandoned partial frame, then a good one
      ps2_bits(frame_of(8'h55, 0, 0), 5, 0);
      wait_clk(60000);
      send(8'h29, 0, 0, 0);
      bus_read(2'd1, d);
      chk("timeout_status", d, 32'h0000_0101);
      read_data_chk("timeout_data");

      // glitches on the clock line
      send(8'h5A, 0, 0, 1);
      status_chk("glitch_status");
      read_data_chk("glitch_data");

      // writes to DATA and offset 3 are ignored; offset 3 reads 0
      send(8'h77, 0, 0, 0);
      bus_write(2'd0, 32'hFF, 4'hF);
      bus_write(2'd3, 32'hFF, 4'hF);
      bus_read(2'd3, d);
      chk("off3_read", d, 32'h0);
      status_chk("ignored_writes");
      read_data_chk("ignored_data");

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 4)
            send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
         else if (r <= 6) read_data_chk("rnd_data");
         else if (r == 7) status_chk("rnd_status");
         else begin
            bus_write(2'd1, {28'h0, 4'($urandom)}, {3'h0, 1'($urandom)});
            status_chk("rnd_w1c");
         end
      end
      while (mq.size() != 0) read_data_chk("final_drain");
      status_chk("final_status");

      // reset mid-frame with bytes queued
      bus_write(2'd2, 32'h1, 4'h1);
      for (int i = 0; i < 3; i++) send(8'($urandom), 0, 0, 0);
      wait_clk(3);
      chk("pre_reset_irq", {31'h0, IRQ_H}, 32'h1);
      ps2_bits(frame_of(8'hA5, 0, 0), 5, 0);
      @(negedge Clock);
      Reset_L = 1'b0;
      bus.Keyboard_Select_H = 1'b1; bus.AS_L = 1'b0; bus.WE_L = 1'b1; bus.Address = 32'h4;
      #1 chk("rst_status", bus.DataOut, 32'h0);
      chk("rst_irq", {31'h0, IRQ_H}, 32'h0);
      bus.Address = 32'h8;
      #1 chk("rst_ie", bus.DataOut, 32'h0);
      bus_idle();
      mq.delete(); m_ovr = 0; m_perr = 0; m_ferr = 0;
      wait_clk(3);
      @(negedge Clock) Reset_L = 1'b1;
      wait_clk(5);
      send(8'h3B, 0, 0, 0);
      status_chk("post_rst_status");
      read_data_chk("post_rst_data");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
